// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: channel indices, channel FSM encoding, counter sizing.
package btn_pkg;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        HELD         = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_e;

    // One counter serves debounce and both repeat intervals, so it must hold the largest of them.
    function automatic int cnt_width(int debounce, int delay, int period);
        int m;
        m = debounce;
        if (delay > m) m = delay;
        if (period > m) m = period;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the conditioner outputs consumed by cursor/game logic.
interface btn_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output any_press
    );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM and optional auto-repeat.
// Press/release accepted after 2 + DEBOUNCE_CYCLES edges; level and pulse are registered.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 15_000_000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          phase_q, phase_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic          s;

    assign s = sync2_q;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT_EN) begin
                    // phase_q=0 waits the long first delay, phase_q=1 the shorter period.
                    if (cnt_q == (phase_q ? PER_LAST : DLY_LAST)) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        phase_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the board pushbuttons into debounced levels and press/repeat strobes.
// Latency 2 + DEBOUNCE_CYCLES edges per press; no backpressure, outputs are one-cycle strobes.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter int               REPEAT_DELAY    = 50_000_000,
    parameter int               REPEAT_PERIOD   = 15_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(5'b01111)
) (
    input  logic               clk,
    input  logic               reset,
    btn_conditioner_if.slave   io
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("REPEAT_DELAY must be at least 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_period
        $error("REPEAT_PERIOD must be at least 2");
    end

    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] pulse_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_raw   (io.btn_raw[i]),
            .btn_level (level_w[i]),
            .btn_pulse (pulse_w[i])
        );
    end

    assign io.btn_level = level_w;
    assign io.btn_pulse = pulse_w;
    assign io.any_press = |pulse_w;

endmodule
